// File: rtl/ctrl_pkg.sv
// Shared constants for the ID-stage controller: opcodes, control-word layout, width codes, sequencer states.
// Purely declarative; no logic, no latency.
package ctrl_pkg;

   localparam int CTRL_W = 15;
   localparam int CNT_W  = 5;

   // Control word bit offsets, LSB first
   localparam int B_JAL      = 0;
   localparam int B_REGWRITE = 1;
   localparam int B_MEMTOREG = 2;
   localparam int B_WWIDTH   = 3;
   localparam int B_RWIDTH   = 5;
   localparam int B_WEN      = 7;
   localparam int B_REN      = 8;
   localparam int B_ALUSRC1  = 9;
   localparam int B_ALUSRC0  = 11;
   localparam int B_REGDST   = 12;
   localparam int B_REGSRC1  = 13;
   localparam int B_REGSRC0  = 14;

   localparam logic [1:0] WORD = 2'd0;
   localparam logic [1:0] HALF = 2'd1;
   localparam logic [1:0] BYTE = 2'd2;

   localparam logic [CTRL_W-1:0] BUBBLE = '0;

   localparam logic [5:0] OP_RTYPE  = 6'b000000;
   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_J      = 6'b000010;
   localparam logic [5:0] OP_JAL    = 6'b000011;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_BLEZ   = 6'b000110;
   localparam logic [5:0] OP_BGTZ   = 6'b000111;
   localparam logic [5:0] OP_ADDI   = 6'b001000;
   localparam logic [5:0] OP_SLTI   = 6'b001010;
   localparam logic [5:0] OP_ANDI   = 6'b001100;
   localparam logic [5:0] OP_ORI    = 6'b001101;
   localparam logic [5:0] OP_XORI   = 6'b001110;
   localparam logic [5:0] OP_MUL    = 6'b011100;
   localparam logic [5:0] OP_LB     = 6'b100000;
   localparam logic [5:0] OP_LH     = 6'b100001;
   localparam logic [5:0] OP_LW     = 6'b100011;
   localparam logic [5:0] OP_SB     = 6'b101000;
   localparam logic [5:0] OP_SH     = 6'b101001;
   localparam logic [5:0] OP_SW     = 6'b101011;

   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_SRL = 6'b000010;
   localparam logic [5:0] FN_JR  = 6'b001000;

   typedef enum logic {S_IDLE, S_MUL_BUSY} seq_state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct decoder: control word, illegal flag and source-register usage.
// Zero latency; no flow control (an invalid slot decodes to an all-zero word).
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [5:0]        opcode,
   input  logic [5:0]        funct,
   input  logic              id_valid,
   output logic [CTRL_W-1:0] ctrl,
   output logic              illegal,
   output logic              rs_used,
   output logic              rt_used
);

   logic [CTRL_W-1:0] c;
   logic              ill;
   logic              rs_u;
   logic              rt_u;

   always_comb begin
      c    = BUBBLE;
      ill  = 1'b0;
      rs_u = 1'b1;
      rt_u = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            rt_u = 1'b1;
            if (funct != FN_JR) begin
               c[B_REGDST]   = 1'b1;
               c[B_MEMTOREG] = 1'b1;
               c[B_REGWRITE] = 1'b1;
               if (funct == FN_SLL || funct == FN_SRL) begin
                  rs_u          = 1'b0;
                  c[B_ALUSRC0]  = 1'b1;
               end
            end
         end
         OP_MUL: begin
            rt_u          = 1'b1;
            c[B_REGDST]   = 1'b1;
            c[B_MEMTOREG] = 1'b1;
            c[B_REGWRITE] = 1'b1;
         end
         OP_LW, OP_LH, OP_LB: begin
            c[B_ALUSRC1 +: 2] = 2'd1;
            c[B_REN]          = 1'b1;
            c[B_REGWRITE]     = 1'b1;
            c[B_RWIDTH +: 2]  = (opcode == OP_LW) ? WORD : (opcode == OP_LH) ? HALF : BYTE;
         end
         OP_SW, OP_SH, OP_SB: begin
            rt_u              = 1'b1;
            c[B_ALUSRC1 +: 2] = 2'd1;
            c[B_WEN]          = 1'b1;
            c[B_WWIDTH +: 2]  = (opcode == OP_SW) ? WORD : (opcode == OP_SH) ? HALF : BYTE;
         end
         OP_BEQ, OP_BNE: begin
            rt_u          = 1'b1;
            c[B_REGSRC0]  = 1'b1;
         end
         // Compare-against-zero branches take the second operand from $0
         OP_REGIMM, OP_BGTZ, OP_BLEZ: begin
            c[B_REGSRC0] = 1'b1;
            c[B_REGSRC1] = 1'b1;
         end
         OP_J: begin
            rs_u              = 1'b0;
            c[B_ALUSRC1 +: 2] = 2'd2;
         end
         OP_JAL: begin
            rs_u              = 1'b0;
            c[B_ALUSRC1 +: 2] = 2'd2;
            c[B_REGWRITE]     = 1'b1;
            c[B_JAL]          = 1'b1;
         end
         OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: begin
            c[B_ALUSRC1 +: 2] = 2'd1;
            c[B_MEMTOREG]     = 1'b1;
            c[B_REGWRITE]     = 1'b1;
         end
         default: ill = 1'b1;
      endcase
      if (!id_valid || ill) begin
         c    = BUBBLE;
         rs_u = 1'b0;
         rt_u = 1'b0;
      end
   end

   assign ctrl    = c;
   assign illegal = ill & id_valid;
   assign rs_used = rs_u;
   assign rt_used = rt_u;

endmodule

// File: rtl/ctrl_hazard_stage.sv
// ID/EX control register with load-use interlock, multi-cycle mul sequencer, external hold and flush.
// 1-cycle decode-to-EX latency; holds PC and IF/ID (PC_Write/IFID_Write low) on stall, mul busy or hazard.
module ctrl_hazard_stage
   import ctrl_pkg::*;
#(
   parameter int MUL_CYCLES = 3,
   parameter int REG_AW     = 5
)(
   input  logic              Clk,
   input  logic              Reset,
   input  logic [31:0]       Instruction,
   input  logic              ID_Valid,
   input  logic              Flush,
   input  logic              Ext_Stall,
   output logic [CTRL_W-1:0] Ctrl_EX,
   output logic [REG_AW-1:0] Dest_EX,
   output logic              Valid_EX,
   output logic              Illegal_EX,
   output logic              PC_Write,
   output logic              IFID_Write,
   output logic              Busy
);

   logic [5:0]        opcode;
   logic [REG_AW-1:0] rs, rt, rd;
   logic [CTRL_W-1:0] dec_ctrl;
   logic              dec_ill, rs_used, rt_used;
   logic [REG_AW-1:0] dec_dest;
   logic              hazard, mul_id;
   logic              unused_shamt;

   seq_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CTRL_W-1:0] ctrl_d;
   logic [REG_AW-1:0] dest_d;
   logic              valid_d, ill_d;

   assign opcode       = Instruction[31:26];
   assign rs           = REG_AW'(Instruction[25:21]);
   assign rt           = REG_AW'(Instruction[20:16]);
   assign rd           = REG_AW'(Instruction[15:11]);
   assign unused_shamt = ^Instruction[10:6];

   ctrl_decode u_decode (
      .opcode   (opcode),
      .funct    (Instruction[5:0]),
      .id_valid (ID_Valid),
      .ctrl     (dec_ctrl),
      .illegal  (dec_ill),
      .rs_used  (rs_used),
      .rt_used  (rt_used)
   );

   assign dec_dest = dec_ctrl[B_JAL]    ? REG_AW'(31) :
                     dec_ctrl[B_REGDST] ? rd : rt;

   assign mul_id = ID_Valid & (opcode == OP_MUL);

   assign hazard = Valid_EX & Ctrl_EX[B_REN] & (Dest_EX != '0) &
                   ((rs_used & (rs == Dest_EX)) | (rt_used & (rt == Dest_EX)));

   assign Busy       = (state_q == S_MUL_BUSY);
   assign PC_Write   = Flush | ~(Ext_Stall | Busy | hazard);
   assign IFID_Write = PC_Write;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ctrl_d  = Ctrl_EX;
      dest_d  = Dest_EX;
      valid_d = Valid_EX;
      ill_d   = Illegal_EX;
      if (Flush) begin
         ctrl_d  = BUBBLE;
         dest_d  = '0;
         valid_d = 1'b0;
         ill_d   = 1'b0;
         state_d = S_IDLE;
         cnt_d   = '0;
      end else if (Ext_Stall) begin
         state_d = state_q;
      end else if (state_q == S_MUL_BUSY) begin
         ctrl_d  = BUBBLE;
         dest_d  = '0;
         valid_d = 1'b0;
         ill_d   = 1'b0;
         cnt_d   = cnt_q - 1'b1;
         if (cnt_q == CNT_W'(1))
            state_d = S_IDLE;
      end else if (hazard) begin
         ctrl_d  = BUBBLE;
         dest_d  = '0;
         valid_d = 1'b0;
         ill_d   = 1'b0;
      end else begin
         ctrl_d  = dec_ctrl;
         dest_d  = dec_dest;
         valid_d = ID_Valid;
         ill_d   = dec_ill;
         // The mul itself issues now; the sequencer only blocks what follows it
         if (mul_id && MUL_CYCLES > 1) begin
            state_d = S_MUL_BUSY;
            cnt_d   = CNT_W'(MUL_CYCLES - 1);
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         Ctrl_EX    <= BUBBLE;
         Dest_EX    <= '0;
         Valid_EX   <= 1'b0;
         Illegal_EX <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         Ctrl_EX    <= ctrl_d;
         Dest_EX    <= dest_d;
         Valid_EX   <= valid_d;
         Illegal_EX <= ill_d;
      end
   end

endmodule

// File: tb/tb_ctrl_hazard_stage.sv
// Directed bench for ctrl_hazard_stage: one instance with MUL_CYCLES=3, one with MUL_CYCLES=1, shared inputs.
module tb_ctrl_hazard_stage;
   import ctrl_pkg::*;

   logic              Clk = 1'b0;
   logic              Reset;
   logic [31:0]       Instruction;
   logic              ID_Valid, Flush, Ext_Stall;
   logic [CTRL_W-1:0] Ctrl_EX;
   logic [4:0]        Dest_EX;
   logic              Valid_EX, Illegal_EX, PC_Write, IFID_Write, Busy;
   logic [CTRL_W-1:0] c1_unused_ctrl;
   logic [4:0]        c1_dest;
   logic              c1_valid, c1_unused_ill, c1_pcw, c1_unused_ifid, c1_busy;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [5:0] FN_ADD = 6'b100000;

   always #5 Clk = ~Clk;

   ctrl_hazard_stage #(.MUL_CYCLES(3), .REG_AW(5)) dut (
      .Clk(Clk), .Reset(Reset), .Instruction(Instruction), .ID_Valid(ID_Valid),
      .Flush(Flush), .Ext_Stall(Ext_Stall), .Ctrl_EX(Ctrl_EX), .Dest_EX(Dest_EX),
      .Valid_EX(Valid_EX), .Illegal_EX(Illegal_EX), .PC_Write(PC_Write),
      .IFID_Write(IFID_Write), .Busy(Busy)
   );

   ctrl_hazard_stage #(.MUL_CYCLES(1), .REG_AW(5)) dut1 (
      .Clk(Clk), .Reset(Reset), .Instruction(Instruction), .ID_Valid(ID_Valid),
      .Flush(Flush), .Ext_Stall(Ext_Stall), .Ctrl_EX(c1_unused_ctrl), .Dest_EX(c1_dest),
      .Valid_EX(c1_valid), .Illegal_EX(c1_unused_ill), .PC_Write(c1_pcw),
      .IFID_Write(c1_unused_ifid), .Busy(c1_busy)
   );

   function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] mul_ins(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd);
      return {OP_MUL, rs, rt, rd, 5'd0, 6'b000010};
   endfunction

   // Registered outputs are sampled 1 time unit after the rising edge
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] ins, input logic vld);
      Instruction = ins;
      ID_Valid    = vld;
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1; Flush = 1'b0; Ext_Stall = 1'b0; ID_Valid = 1'b0; Instruction = '0;
      tick(); tick();
      n_tests++; if (Ctrl_EX !== 15'd0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0", Ctrl_EX); end
      n_tests++; if (Dest_EX !== 5'd0) begin n_fail++; $display("FAIL reset_dest: got %0d want 0", Dest_EX); end
      n_tests++; if (Valid_EX !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", Valid_EX); end
      n_tests++; if (Illegal_EX !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", Illegal_EX); end
      n_tests++; if (PC_Write !== 1'b1 || IFID_Write !== 1'b1) begin n_fail++; $display("FAIL reset_write: got %b%b want 11", PC_Write, IFID_Write); end
      n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", Busy); end
      Reset = 1'b0;
   endtask

   task automatic test_immediate();
      drive(i_ins(OP_ADDI, 5'd0, 5'd8, 16'd5), 1'b1);
      tick();
      n_tests++; if (Ctrl_EX[B_ALUSRC1 +: 2] !== 2'd1) begin n_fail++; $display("FAIL addi_alusrc1: got %0d want 1", Ctrl_EX[B_ALUSRC1 +: 2]); end
      n_tests++; if (Ctrl_EX[B_MEMTOREG] !== 1'b1 || Ctrl_EX[B_REGWRITE] !== 1'b1) begin n_fail++; $display("FAIL addi_wb: got m2r=%b rw=%b want 1 1", Ctrl_EX[B_MEMTOREG], Ctrl_EX[B_REGWRITE]); end
      n_tests++; if (Dest_EX !== 5'd8 || Valid_EX !== 1'b1) begin n_fail++; $display("FAIL addi_dest: got %0d v=%b want 8 v=1", Dest_EX, Valid_EX); end
      drive(i_ins(OP_ORI, 5'd8, 5'd8, 16'h000f), 1'b1);
      n_tests++; if (PC_Write !== 1'b1) begin n_fail++; $display("FAIL ori_nostall: got %b want 1", PC_Write); end
      tick();
      n_tests++; if (Ctrl_EX[B_ALUSRC1 +: 2] !== 2'd1 || Ctrl_EX[B_MEMTOREG] !== 1'b1 || Ctrl_EX[B_REGWRITE] !== 1'b1) begin n_fail++; $display("FAIL ori_ctrl: got %h want alusrc1=1 m2r=1 rw=1", Ctrl_EX); end
      n_tests++; if (Dest_EX !== 5'd8 || Ctrl_EX[B_REN] !== 1'b0) begin n_fail++; $display("FAIL ori_dest: got %0d ren=%b want 8 ren=0", Dest_EX, Ctrl_EX[B_REN]); end
      drive('0, 1'b0);
      tick();
   endtask

   task automatic test_load_use();
      drive(i_ins(OP_LW, 5'd4, 5'd9, 16'd0), 1'b1);
      tick();
      n_tests++; if (Ctrl_EX[B_REN] !== 1'b1 || Dest_EX !== 5'd9) begin n_fail++; $display("FAIL lw_issue: got ren=%b dest=%0d want 1 9", Ctrl_EX[B_REN], Dest_EX); end
      drive(r_ins(5'd9, 5'd3, 5'd10, FN_ADD), 1'b1);
      n_tests++; if (PC_Write !== 1'b0 || IFID_Write !== 1'b0) begin n_fail++; $display("FAIL lu_hold: got %b%b want 00", PC_Write, IFID_Write); end
      tick();
      n_tests++; if (Valid_EX !== 1'b0 || Ctrl_EX !== 15'd0) begin n_fail++; $display("FAIL lu_bubble: got v=%b ctrl=%h want 0 0", Valid_EX, Ctrl_EX); end
      #1;
      n_tests++; if (PC_Write !== 1'b1) begin n_fail++; $display("FAIL lu_release: got %b want 1", PC_Write); end
      tick();
      n_tests++; if (Valid_EX !== 1'b1 || Dest_EX !== 5'd10 || Ctrl_EX[B_REGDST] !== 1'b1) begin n_fail++; $display("FAIL lu_add_issue: got v=%b dest=%0d want 1 10", Valid_EX, Dest_EX); end
      drive(i_ins(OP_LW, 5'd4, 5'd0, 16'd0), 1'b1);
      tick();
      drive(r_ins(5'd0, 5'd3, 5'd10, FN_ADD), 1'b1);
      n_tests++; if (PC_Write !== 1'b1) begin n_fail++; $display("FAIL lu_zero_nostall: got %b want 1", PC_Write); end
      tick();
      n_tests++; if (Valid_EX !== 1'b1 || Dest_EX !== 5'd10) begin n_fail++; $display("FAIL lu_zero_issue: got v=%b dest=%0d want 1 10", Valid_EX, Dest_EX); end
      drive('0, 1'b0);
      tick();
   endtask

   task automatic test_mul();
      drive(mul_ins(5'd3, 5'd4, 5'd2), 1'b1);
      n_tests++; if (PC_Write !== 1'b1) begin n_fail++; $display("FAIL mul_issue_adv: got %b want 1", PC_Write); end
      tick();
      n_tests++; if (Valid_EX !== 1'b1 || Dest_EX !== 5'd2 || Busy !== 1'b1) begin n_fail++; $display("FAIL mul_issue: got v=%b dest=%0d busy=%b want 1 2 1", Valid_EX, Dest_EX, Busy); end
      n_tests++; if (c1_busy !== 1'b0 || c1_pcw !== 1'b1) begin n_fail++; $display("FAIL mul1_nobusy: got busy=%b pcw=%b want 0 1", c1_busy, c1_pcw); end
      drive(r_ins(5'd6, 5'd7, 5'd5, FN_ADD), 1'b1);
      n_tests++; if (PC_Write !== 1'b0) begin n_fail++; $display("FAIL mul_hold: got %b want 0", PC_Write); end
      tick();
      n_tests++; if (Valid_EX !== 1'b0 || Busy !== 1'b1) begin n_fail++; $display("FAIL mul_bubble1: got v=%b busy=%b want 0 1", Valid_EX, Busy); end
      n_tests++; if (c1_valid !== 1'b1 || c1_dest !== 5'd5) begin n_fail++; $display("FAIL mul1_add_issue: got v=%b dest=%0d want 1 5", c1_valid, c1_dest); end
      tick();
      n_tests++; if (Valid_EX !== 1'b0 || Busy !== 1'b0) begin n_fail++; $display("FAIL mul_bubble2: got v=%b busy=%b want 0 0", Valid_EX, Busy); end
      tick();
      n_tests++; if (Valid_EX !== 1'b1 || Dest_EX !== 5'd5) begin n_fail++; $display("FAIL mul_add_issue: got v=%b dest=%0d want 1 5", Valid_EX, Dest_EX); end
      drive('0, 1'b0);
      tick();
   endtask

   task automatic test_flush_hazard();
      drive(i_ins(OP_LW, 5'd4, 5'd9, 16'd0), 1'b1);
      tick();
      Flush = 1'b1;
      drive(r_ins(5'd9, 5'd3, 5'd10, FN_ADD), 1'b1);
      n_tests++; if (PC_Write !== 1'b1 || IFID_Write !== 1'b1) begin n_fail++; $display("FAIL flush_write: got %b%b want 11", PC_Write, IFID_Write); end
      tick();
      n_tests++; if (Valid_EX !== 1'b0 || Ctrl_EX !== 15'd0 || Illegal_EX !== 1'b0) begin n_fail++; $display("FAIL flush_bubble: got v=%b ctrl=%h ill=%b want 0 0 0", Valid_EX, Ctrl_EX, Illegal_EX); end
      Flush = 1'b0;
      drive('0, 1'b0);
      tick();
   endtask

   task automatic test_stall_mul();
      drive(mul_ins(5'd3, 5'd4, 5'd2), 1'b1);
      tick();
      Ext_Stall = 1'b1;
      drive(r_ins(5'd6, 5'd7, 5'd5, FN_ADD), 1'b1);
      for (int i = 0; i < 3; i++) begin
         n_tests++; if (PC_Write !== 1'b0) begin n_fail++; $display("FAIL stall_hold%0d: got %b want 0", i, PC_Write); end
         tick();
         n_tests++; if (Busy !== 1'b1 || Valid_EX !== 1'b1 || Dest_EX !== 5'd2) begin n_fail++; $display("FAIL stall_frozen%0d: got busy=%b v=%b dest=%0d want 1 1 2", i, Busy, Valid_EX, Dest_EX); end
      end
      Ext_Stall = 1'b0;
      tick();
      n_tests++; if (Valid_EX !== 1'b0 || Busy !== 1'b1) begin n_fail++; $display("FAIL stall_bubble1: got v=%b busy=%b want 0 1", Valid_EX, Busy); end
      tick();
      n_tests++; if (Valid_EX !== 1'b0 || Busy !== 1'b0) begin n_fail++; $display("FAIL stall_bubble2: got v=%b busy=%b want 0 0", Valid_EX, Busy); end
      tick();
      n_tests++; if (Valid_EX !== 1'b1 || Dest_EX !== 5'd5) begin n_fail++; $display("FAIL stall_add_issue: got v=%b dest=%0d want 1 5", Valid_EX, Dest_EX); end
      drive('0, 1'b0);
      tick();
   endtask

   task automatic test_illegal_jal();
      drive({6'b111111, 26'h0}, 1'b1);
      tick();
      n_tests++; if (Illegal_EX !== 1'b1 || Valid_EX !== 1'b1) begin n_fail++; $display("FAIL ill_flag: got ill=%b v=%b want 1 1", Illegal_EX, Valid_EX); end
      n_tests++; if (Ctrl_EX[B_REGWRITE] !== 1'b0 || Ctrl_EX[B_WEN] !== 1'b0 || Ctrl_EX !== 15'd0) begin n_fail++; $display("FAIL ill_ctrl: got %h want 0", Ctrl_EX); end
      drive({OP_JAL, 26'h10}, 1'b1);
      tick();
      n_tests++; if (Dest_EX !== 5'd31 || Illegal_EX !== 1'b0) begin n_fail++; $display("FAIL jal_dest: got %0d ill=%b want 31 0", Dest_EX, Illegal_EX); end
      n_tests++; if (Ctrl_EX[B_JAL] !== 1'b1 || Ctrl_EX[B_ALUSRC1 +: 2] !== 2'd2) begin n_fail++; $display("FAIL jal_ctrl: got jal=%b alusrc1=%0d want 1 2", Ctrl_EX[B_JAL], Ctrl_EX[B_ALUSRC1 +: 2]); end
      drive('0, 1'b0);
      tick();
   endtask

   task automatic test_reset_mid_busy();
      drive(mul_ins(5'd3, 5'd4, 5'd2), 1'b1);
      tick();
      drive(r_ins(5'd6, 5'd7, 5'd5, FN_ADD), 1'b1);
      n_tests++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy_pre: got %b want 1", Busy); end
      Reset = 1'b1;
      #1;
      n_tests++; if (Busy !== 1'b0 || PC_Write !== 1'b1 || Valid_EX !== 1'b0) begin n_fail++; $display("FAIL rst_busy_release: got busy=%b pcw=%b v=%b want 0 1 0", Busy, PC_Write, Valid_EX); end
      tick();
      Reset = 1'b0;
      drive('0, 1'b0);
      tick();
   endtask

   initial begin
      test_reset();
      test_immediate();
      test_load_use();
      test_mul();
      test_flush_hazard();
      test_stall_mul();
      test_illegal_jal();
      test_reset_mid_busy();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ctrl_hazard_stage.md
# ctrl_hazard_stage

Pipelined successor to the combinational opcode/funct controller. Decodes the instruction held in IF/ID into a packed control word, registers it together with the destination register into the ID/EX boundary, and owns front-end stall and bubble generation. Covers load-use interlock, a parametrised multi-cycle `mul` sequencer, external hold, and branch flush. Sits between the IF/ID register and the EX stage.

## Interface
- `MUL_CYCLES`, default 3: EX occupancy of `mul` in cycles; legal range 1..16.
- `REG_AW`, default 5: register-address width.
- `Clk` in 1: single clock, rising edge.
- `Reset` in 1: asynchronous, active-high.
- `Instruction` in 32: IF/ID instruction; opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0].
- `ID_Valid` in 1: IF/ID holds a real instruction.
- `Flush` in 1: branch/jump taken in EX; kill the instruction in ID.
- `Ext_Stall` in 1: downstream hold; freeze all state.
- `Ctrl_EX` out 15: registered control word {RegSrc0, RegSrc1, RegDst, ALUSrc0, ALUSrc1[1:0], R_Enable, W_Enable, R_Width[1:0], W_Width[1:0], MemToReg, RegWrite, Jal}.
- `Dest_EX` out REG_AW: registered write register.
- `Valid_EX` out 1: ID/EX holds a real instruction.
- `Illegal_EX` out 1: registered, undefined opcode/funct.
- `PC_Write` out 1: combinational; 0 holds the PC.
- `IFID_Write` out 1: combinational; 0 holds IF/ID.
- `Busy` out 1: the mul sequencer is active.

## Operation
- Decode encodings:
  - R-type (000000): default, jr 001000, sll 000000, srl 000010.
  - mul: 011100.
  - Loads: lw/lh/lb (R_Width 0/1/2).
  - Stores: sw/sh/sb (W_Width 0/1/2).
  - Branches: bgez/bltz 000001, beq, bne, bgtz, blez.
  - Jumps: j, jal (ALUSrc1=2, Jal=1).
  - Immediates: addi, andi, ori, xori, slti (ALUSrc1=1, MemToReg=1, RegWrite=1).
  - Any other encoding: all-zero word, Illegal=1.
  - Unused width fields are driven 0, never X.
- Dest selection: jal → 31; RegDst=1 → rd; otherwise rt.
- Source use for hazards:
  - rs is used by every legal instruction except j, jal, sll, srl.
  - rt is used by R-type, mul, beq, bne, sw, sh, sb.
- Load-use hazard condition: Valid_EX & Ctrl_EX.R_Enable & Dest_EX≠0 & Dest_EX equals a used source of the ID instruction.
- Sequencer state machine:
  - IDLE → MUL_BUSY when a mul is loaded into ID/EX and MUL_CYCLES>1; counter loads MUL_CYCLES-1.
  - MUL_BUSY: decrement each non-held cycle; → IDLE when the counter reaches 1 and decrements.
  - Busy=1 exactly in MUL_BUSY.
- ID/EX update priority, per edge:
  1. Reset.
  2. Flush: load a bubble (all-zero word, Valid 0, Illegal 0); state → IDLE.
  3. Ext_Stall: hold everything, including the counter.
  4. MUL_BUSY: load a bubble.
  5. Load-use hazard: load a bubble.
  6. Otherwise load the decoded word, with Valid_EX = ID_Valid.
- ID_Valid=0 forces the decoded word to all-zero and raises no hazard.
- PC_Write = IFID_Write = ~(Ext_Stall | MUL_BUSY | hazard | (mul decoded in ID & IDLE & MUL_CYCLES>1 & ~Flush))? No: use PC_Write = IFID_Write = ~(Ext_Stall | MUL_BUSY | hazard). The mul itself advances in its issue cycle.
- When Flush=1, PC_Write = IFID_Write = 1.

## Timing
- Decode-to-Ctrl_EX latency: 1 cycle.
- Reset (async) values:
  - Ctrl_EX=0, Dest_EX=0, Valid_EX=0, Illegal_EX=0.
  - State IDLE, counter 0, Busy=0.
  - PC_Write=1, IFID_Write=1.
- Load-use interlock: exactly 1 bubble, then the dependent instruction issues.
- mul: issues in cycle N, followed by MUL_CYCLES-1 bubbles, N+1..N+MUL_CYCLES-1. The next instruction issues at N+MUL_CYCLES.
- MUL_CYCLES=1: no stall, and the state machine never leaves IDLE.
- Back-to-back muls: the second issues only when the state is IDLE.
- Flush in the same cycle as a hazard or Ext_Stall: Flush wins.
- Reset mid-MUL_BUSY: immediate return to IDLE, and the front end releases.

## Structure
- Package `ctrl_pkg` holds:
  - Opcode/funct constants.
  - Control-word field offsets and CTRL_W=15.
  - Width encodings: WORD=0, HALF=1, BYTE=2.
  - Bubble constant.
- Sub-module `ctrl_decode` is purely combinational and takes opcode, funct, and ID_Valid. It outputs the control word, Illegal, and the rs-used/rt-used flags.
- The top level holds the ID/EX register, hazard compare, counter, and state machine.

## Test plan
- Reset → all ID/EX outputs 0, PC_Write=1, Busy=0.
- addi $8,$0,5 then ori → Ctrl_EX has ALUSrc1=1, MemToReg=1, RegWrite=1, Dest_EX=8, one cycle after each input.
- lw $9,0($4), then add $10,$9,$3 → one bubble; PC_Write=0 for 1 cycle; add reaches EX 2 cycles after lw. Repeat with $0 as the target → no stall.
- MUL_CYCLES=3: mul $2,$3,$4, then add → Busy=1 for 2 cycles, 2 bubbles, add issues 3 cycles after mul. With MUL_CYCLES=1 → no bubbles.
- Flush asserted together with a load-use hazard → bubble loaded, PC_Write=1. Ext_Stall for 3 cycles during MUL_BUSY → counter frozen, total mul stall extends by 3.
- Opcode 111111 → Illegal_EX=1, RegWrite=0, W_Enable=0. jal → Dest_EX=31, Jal=1, ALUSrc1=2.
